decode_stage: RTL and testbench

Parametrised, handshaked instruction-decode pipeline stage between fetch and register-read/execute. It accepts one 32-bit RV64IM/RV32IM instruction per cycle with its PC and produces ALU control, register addresses, a sign-extended immediate, an operand-B select and an instruction class. It buffers through a two-entry skid register so back-pressure never drops or duplicates an instruction. It supersedes the ALU-only decoder: it covers loads, stores, branches, jumps, LUI/AUIPC and illegal detection, and supports a flush.

---
 rtl/decode_pkg.sv | 43 ++++
 rtl/decode_stage_comb.sv | 141 ++++++++++++++
 rtl/decode_stage.sv | 81 ++++++++
 tb/tb_decode_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types and encodings for the instruction decode stage: ALU codes,
// major opcodes, instruction classes and the decoded bundle.
package decode_pkg;

    localparam int ALU_BITS = 6;

    // ALU codes retain the encodings of the earlier ALU-only decoder.
    localparam logic [ALU_BITS-1:0]
        ALU_NONE  = 6'd0,  ALU_ADDI   = 6'd1,  ALU_SLTI  = 6'd2,  ALU_SLTIU = 6'd3,
        ALU_XORI  = 6'd4,  ALU_ORI    = 6'd5,  ALU_ANDI  = 6'd6,  ALU_SLLI  = 6'd7,
        ALU_SRLI  = 6'd8,  ALU_SRAI   = 6'd9,  ALU_LUI   = 6'd10, ALU_AUIPC = 6'd11,
        ALU_ADD   = 6'd12, ALU_SUB    = 6'd13, ALU_SLL   = 6'd14, ALU_SLT   = 6'd15,
        ALU_SLTU  = 6'd16, ALU_XOR    = 6'd17, ALU_SRL   = 6'd18, ALU_SRA   = 6'd19,
        ALU_OR    = 6'd20, ALU_AND    = 6'd21, ALU_ADDIW = 6'd22, ALU_SLLIW = 6'd23,
        ALU_SRLIW = 6'd24, ALU_SRAIW  = 6'd25, ALU_ADDW  = 6'd26, ALU_SUBW  = 6'd27,
        ALU_SLLW  = 6'd28, ALU_SRLW   = 6'd29, ALU_SRAW  = 6'd30, ALU_MUL   = 6'd31,
        ALU_MULH  = 6'd32, ALU_MULHSU = 6'd33, ALU_MULHU = 6'd34, ALU_DIV   = 6'd35,
        ALU_DIVU  = 6'd36, ALU_REM    = 6'd37, ALU_REMU  = 6'd38, ALU_MULW  = 6'd39,
        ALU_DIVW  = 6'd40, ALU_DIVUW  = 6'd41, ALU_REMW  = 6'd42, ALU_REMUW = 6'd43;

    localparam logic [6:0]
        OPC_LOAD   = 7'h03, OPC_OP_IMM = 7'h13, OPC_AUIPC  = 7'h17, OPC_OP_IMM_32 = 7'h1B,
        OPC_STORE  = 7'h23, OPC_OP     = 7'h33, OPC_LUI    = 7'h37, OPC_OP_32     = 7'h3B,
        OPC_BRANCH = 7'h63, OPC_JALR   = 7'h67, OPC_JAL    = 7'h6F;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_UPPER, CLS_SYSTEM
    } cls_e;

    // imm and pc are carried at the widest XLEN; narrower builds truncate.
    typedef struct packed {
        logic [ALU_BITS-1:0] alu;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [63:0]         imm;
        logic                muxb;
        cls_e                cls;
        logic [63:0]         pc;
        logic                illegal;
    } decoded_t;

endpackage

// File: rtl/decode_stage_comb.sv
// Purely combinational instruction-word to decoded_t translation for RV32IM/RV64IM.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     ins,
    input  logic [XLEN-1:0] pc,
    output decoded_t        dec
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        shamt_lsb_ok;
    logic        legal;
    logic [63:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign opcode = ins[6:0];
    assign f3     = ins[14:12];
    assign f7     = ins[31:25];
    // On RV32 ins[25] is shamt[5], which does not exist.
    assign shamt_lsb_ok = RV64 || !ins[25];

    assign imm_i = {{52{ins[31]}}, ins[31:20]};
    assign imm_s = {{52{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{52{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_j = {{44{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    assign imm_u = {{32{ins[31]}}, ins[31:12], 12'b0};

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        dec     = '0;
        legal   = 1'b1;
        dec.pc  = 64'(pc);
        dec.rs1 = ins[19:15];
        dec.rs2 = ins[24:20];
        dec.rd  = ins[11:7];
        case (opcode)
            OPC_OP_IMM: begin
                dec.rs2 = '0; dec.imm = imm_i; dec.muxb = 1'b1;
                case (f3)
                    3'd0: dec.alu = ALU_ADDI;
                    3'd1: if (ins[31:26] == 6'b0 && shamt_lsb_ok) dec.alu = ALU_SLLI;
                          else legal = 1'b0;
                    3'd2: dec.alu = ALU_SLTI;
                    3'd3: dec.alu = ALU_SLTIU;
                    3'd4: dec.alu = ALU_XORI;
                    3'd5: if (ins[31:26] == 6'b0 && shamt_lsb_ok) dec.alu = ALU_SRLI;
                          else if (ins[31:26] == 6'b010000 && shamt_lsb_ok) dec.alu = ALU_SRAI;
                          else legal = 1'b0;
                    3'd6: dec.alu = ALU_ORI;
                    default: dec.alu = ALU_ANDI;
                endcase
            end
            OPC_OP_IMM_32: begin
                dec.rs2 = '0; dec.imm = imm_i; dec.muxb = 1'b1;
                if (!RV64) legal = 1'b0;
                case ({f7, f3})
                    {7'h00, 3'd0}, {7'h01, 3'd0}, {7'h20, 3'd0}: dec.alu = ALU_ADDIW;
                    {7'h00, 3'd1}: dec.alu = ALU_SLLIW;
                    {7'h00, 3'd5}: dec.alu = ALU_SRLIW;
                    {7'h20, 3'd5}: dec.alu = ALU_SRAIW;
                    default: if (f3 == 3'd0) dec.alu = ALU_ADDIW; else legal = 1'b0;
                endcase
            end
            OPC_OP: begin
                case ({f7, f3})
                    {7'h00, 3'd0}: dec.alu = ALU_ADD;   {7'h20, 3'd0}: dec.alu = ALU_SUB;
                    {7'h00, 3'd1}: dec.alu = ALU_SLL;   {7'h00, 3'd2}: dec.alu = ALU_SLT;
                    {7'h00, 3'd3}: dec.alu = ALU_SLTU;  {7'h00, 3'd4}: dec.alu = ALU_XOR;
                    {7'h00, 3'd5}: dec.alu = ALU_SRL;   {7'h20, 3'd5}: dec.alu = ALU_SRA;
                    {7'h00, 3'd6}: dec.alu = ALU_OR;    {7'h00, 3'd7}: dec.alu = ALU_AND;
                    {7'h01, 3'd0}: dec.alu = ALU_MUL;   {7'h01, 3'd1}: dec.alu = ALU_MULH;
                    {7'h01, 3'd2}: dec.alu = ALU_MULHSU; {7'h01, 3'd3}: dec.alu = ALU_MULHU;
                    {7'h01, 3'd4}: dec.alu = ALU_DIV;   {7'h01, 3'd5}: dec.alu = ALU_DIVU;
                    {7'h01, 3'd6}: dec.alu = ALU_REM;   {7'h01, 3'd7}: dec.alu = ALU_REMU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_32: begin
                if (!RV64) legal = 1'b0;
                case ({f7, f3})
                    {7'h00, 3'd0}: dec.alu = ALU_ADDW;  {7'h20, 3'd0}: dec.alu = ALU_SUBW;
                    {7'h00, 3'd1}: dec.alu = ALU_SLLW;  {7'h00, 3'd5}: dec.alu = ALU_SRLW;
                    {7'h20, 3'd5}: dec.alu = ALU_SRAW;  {7'h01, 3'd0}: dec.alu = ALU_MULW;
                    {7'h01, 3'd4}: dec.alu = ALU_DIVW;  {7'h01, 3'd5}: dec.alu = ALU_DIVUW;
                    {7'h01, 3'd6}: dec.alu = ALU_REMW;  {7'h01, 3'd7}: dec.alu = ALU_REMUW;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec.cls = CLS_LOAD; dec.alu = ALU_ADDI; dec.rs2 = '0;
                dec.imm = imm_i; dec.muxb = 1'b1;
                case (f3)
                    3'd0, 3'd1, 3'd2, 3'd4, 3'd5: legal = 1'b1;
                    3'd3, 3'd6: legal = RV64;
                    default: legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                dec.cls = CLS_STORE; dec.alu = ALU_ADDI; dec.rd = '0;
                dec.imm = imm_s; dec.muxb = 1'b1;
                case (f3)
                    3'd0, 3'd1, 3'd2: legal = 1'b1;
                    3'd3: legal = RV64;
                    default: legal = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                dec.cls = CLS_BRANCH; dec.alu = ALU_NONE; dec.rd = '0; dec.imm = imm_b;
                if (f3 == 3'd2 || f3 == 3'd3) legal = 1'b0;
            end
            OPC_JAL: begin
                dec.cls = CLS_JUMP; dec.rs1 = '0; dec.rs2 = '0;
                dec.imm = imm_j; dec.muxb = 1'b1;
            end
            OPC_JALR: begin
                dec.cls = CLS_JUMP; dec.rs2 = '0; dec.imm = imm_i; dec.muxb = 1'b1;
                if (f3 != 3'd0) legal = 1'b0;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.cls = CLS_UPPER; dec.rs1 = '0; dec.rs2 = '0;
                dec.imm = imm_u; dec.muxb = 1'b1;
                dec.alu = (opcode == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
            end
            default: legal = 1'b0;
        endcase

        // Illegal words still travel as a bundle so the exception is raised in order.
        if (!legal) begin
            dec         = '0;
            dec.pc      = 64'(pc);
            dec.cls     = CLS_SYSTEM;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Handshaked decode stage: combinational decode into a main output register
// backed by a one-entry skid register, with flush.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int ALU_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ins,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ALU_W-1:0] out_alu_control,
    output logic [4:0]       out_addressA,
    output logic [4:0]       out_addressB,
    output logic [4:0]       out_addressC,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_muxB_control,
    output logic [2:0]       out_class,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal
);

    decoded_t dec, main_q, skid_q;
    logic     main_valid, skid_valid;
    logic     accept, main_free;

    decode_comb #(.XLEN(XLEN)) u_comb (
        .ins (in_ins),
        .pc  (in_pc),
        .dec (dec)
    );

    // in_ready depends only on state, so out_ready has no path to it.
    assign in_ready  = !skid_valid;
    assign accept    = in_valid && in_ready;
    assign main_free = !main_valid || out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the bundle registers are reset too, so outputs read as zeros out of reset.
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            // NOTE: non-blocking updates let main and skid swap using pre-edge values.
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= accept;
                if (accept) main_q <= dec;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid        = main_valid;
    assign out_alu_control  = ALU_W'(main_q.alu);
    assign out_addressA     = main_q.rs1;
    assign out_addressB     = main_q.rs2;
    assign out_addressC     = main_q.rd;
    assign out_imm          = main_q.imm[XLEN-1:0];
    assign out_muxB_control = main_q.muxb;
    assign out_class        = main_q.cls;
    assign out_pc           = main_q.pc[XLEN-1:0];
    assign out_illegal      = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized bench for decode_stage, run on an RV64 and an RV32
// instance side by side against a table-driven reference decoder and a FIFO occupancy model.
module tb_decode_stage;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] in_ins = '0;
    logic [63:0] in_pc = '0;

    logic in_ready64, out_valid64, muxb64, ill64;
    logic [5:0] alu64; logic [4:0] a64, b64, c64; logic [63:0] imm64, pc64; logic [2:0] cls64;
    logic in_ready32, out_valid32, muxb32, ill32;
    logic [5:0] alu32; logic [4:0] a32, b32, c32; logic [31:0] imm32, pc32; logic [2:0] cls32;

    decode_stage #(.XLEN(64), .ALU_W(6)) dut64 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready64),
        .in_ins(in_ins), .in_pc(in_pc), .flush(flush), .out_valid(out_valid64),
        .out_ready(out_ready), .out_alu_control(alu64), .out_addressA(a64),
        .out_addressB(b64), .out_addressC(c64), .out_imm(imm64), .out_muxB_control(muxb64),
        .out_class(cls64), .out_pc(pc64), .out_illegal(ill64));

    decode_stage #(.XLEN(32), .ALU_W(6)) dut32 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready32),
        .in_ins(in_ins), .in_pc(in_pc[31:0]), .flush(flush), .out_valid(out_valid32),
        .out_ready(out_ready), .out_alu_control(alu32), .out_addressA(a32),
        .out_addressB(b32), .out_addressC(c32), .out_imm(imm32), .out_muxB_control(muxb32),
        .out_class(cls32), .out_pc(pc32), .out_illegal(ill32));

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] alu; logic [4:0] a, b, c; logic [63:0] imm;
        logic muxb; logic [2:0] cls; logic [63:0] pc; logic ill;
    } exp_t;

    // One legal encoding family: f3/f7 of -1 mean "any value".
    typedef struct { logic [6:0] opc; int f3; int f7; int alu; bit w64; } row_t;

    row_t rows[$];
    exp_t q64[$], q32[$];
    int   total = 0, bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic r(input logic [6:0] opc, input int f3, input int f7, input int alu, input bit w64);
        row_t x;
        x.opc = opc; x.f3 = f3; x.f7 = f7; x.alu = alu; x.w64 = w64;
        rows.push_back(x);
    endtask

    task automatic build_table();
        r('h13,0,-1,1,0); r('h13,2,-1,2,0); r('h13,3,-1,3,0); r('h13,4,-1,4,0);
        r('h13,6,-1,5,0); r('h13,7,-1,6,0); r('h13,1,'h00,7,0); r('h13,5,'h00,8,0); r('h13,5,'h20,9,0);
        r('h1B,0,-1,22,1); r('h1B,1,'h00,23,1); r('h1B,5,'h00,24,1); r('h1B,5,'h20,25,1);
        r('h33,0,0,12,0); r('h33,0,'h20,13,0); r('h33,1,0,14,0); r('h33,2,0,15,0); r('h33,3,0,16,0);
        r('h33,4,0,17,0); r('h33,5,0,18,0); r('h33,5,'h20,19,0); r('h33,6,0,20,0); r('h33,7,0,21,0);
        for (int k = 0; k < 8; k++) r('h33, k, 1, 31 + k, 0);
        r('h3B,0,0,26,1); r('h3B,0,'h20,27,1); r('h3B,1,0,28,1); r('h3B,5,0,29,1); r('h3B,5,'h20,30,1);
        r('h3B,0,1,39,1); r('h3B,4,1,40,1); r('h3B,5,1,41,1); r('h3B,6,1,42,1); r('h3B,7,1,43,1);
        r('h03,0,-1,1,0); r('h03,1,-1,1,0); r('h03,2,-1,1,0); r('h03,4,-1,1,0); r('h03,5,-1,1,0);
        r('h03,3,-1,1,1); r('h03,6,-1,1,1);
        r('h23,0,-1,1,0); r('h23,1,-1,1,0); r('h23,2,-1,1,0); r('h23,3,-1,1,1);
        r('h63,0,-1,0,0); r('h63,1,-1,0,0); r('h63,4,-1,0,0); r('h63,5,-1,0,0);
        r('h63,6,-1,0,0); r('h63,7,-1,0,0);
        r('h67,0,-1,0,0); r('h6F,-1,-1,0,0); r('h37,-1,-1,10,0); r('h17,-1,-1,11,0);
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc, input bit rv64);
        exp_t   e;
        int     hit = -1;
        int     f3 = int'(ins[14:12]);
        int     f7 = int'(ins[31:25]);
        longint sx = longint'($signed(ins));
        // RV64 shift immediates use ins[25] as shamt[5], so it is not part of funct.
        if (ins[6:0] == 7'h13 && (f3 == 1 || f3 == 5) && rv64) f7 = f7 & 'h7E;
        foreach (rows[i])
            if (hit < 0 && rows[i].opc == ins[6:0] && (rows[i].f3 < 0 || rows[i].f3 == f3) &&
                (rows[i].f7 < 0 || rows[i].f7 == f7) && (rv64 || !rows[i].w64)) hit = i;
        e = '{alu: '0, a: '0, b: '0, c: '0, imm: '0, muxb: 1'b0, cls: '0, pc: pc, ill: 1'b0};
        if (hit < 0) begin
            e.cls = 3'd6; e.ill = 1'b1;
            return e;
        end
        e.alu = 6'(rows[hit].alu);
        case (ins[6:0])
            7'h13, 7'h1B: begin e.a = ins[19:15]; e.c = ins[11:7]; e.imm = sx >>> 20; e.muxb = 1; end
            7'h33, 7'h3B: begin e.a = ins[19:15]; e.b = ins[24:20]; e.c = ins[11:7]; end
            7'h03: begin e.cls = 1; e.a = ins[19:15]; e.c = ins[11:7]; e.imm = sx >>> 20; e.muxb = 1; end
            7'h23: begin
                e.cls = 2; e.a = ins[19:15]; e.b = ins[24:20]; e.muxb = 1;
                e.imm = ((sx >>> 25) <<< 5) + longint'(ins[11:7]);
            end
            7'h63: begin
                e.cls = 3; e.a = ins[19:15]; e.b = ins[24:20];
                e.imm = ((sx >>> 31) <<< 12) + (longint'(ins[7]) << 11) +
                        (longint'(ins[30:25]) << 5) + (longint'(ins[11:8]) << 1);
            end
            7'h6F: begin
                e.cls = 4; e.c = ins[11:7]; e.muxb = 1;
                e.imm = ((sx >>> 31) <<< 20) + (longint'(ins[19:12]) << 12) +
                        (longint'(ins[20]) << 11) + (longint'(ins[30:21]) << 1);
            end
            7'h67: begin e.cls = 4; e.a = ins[19:15]; e.c = ins[11:7]; e.imm = sx >>> 20; e.muxb = 1; end
            default: begin e.cls = 5; e.c = ins[11:7]; e.imm = sx & ~64'hFFF; e.muxb = 1; end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] gen_ins();
        logic [31:0] w = $urandom;
        row_t x;
        if ($urandom_range(0, 4) == 0) return w;
        x = rows[$urandom_range(0, rows.size() - 1)];
        w[6:0] = x.opc;
        if (x.f3 >= 0) w[14:12] = x.f3[2:0];
        if (x.f7 >= 0) w[31:25] = x.f7[6:0];
        if (x.opc == 7'h13 && $urandom_range(0, 1) == 1) w[25] = 1'b1;
        return w;
    endfunction

    task automatic check_outputs();
        check("valid64", 64'(out_valid64), 64'(q64.size() > 0));
        check("ready64", 64'(in_ready64), 64'(q64.size() < 2));
        check("valid32", 64'(out_valid32), 64'(q32.size() > 0));
        check("ready32", 64'(in_ready32), 64'(q32.size() < 2));
        if (q64.size() > 0) begin
            check("alu64", 64'(alu64), 64'(q64[0].alu));  check("a64", 64'(a64), 64'(q64[0].a));
            check("b64", 64'(b64), 64'(q64[0].b));        check("c64", 64'(c64), 64'(q64[0].c));
            check("imm64", imm64, q64[0].imm);            check("muxb64", 64'(muxb64), 64'(q64[0].muxb));
            check("cls64", 64'(cls64), 64'(q64[0].cls));  check("pc64", pc64, q64[0].pc);
            check("ill64", 64'(ill64), 64'(q64[0].ill));
        end
        if (q32.size() > 0) begin
            check("alu32", 64'(alu32), 64'(q32[0].alu));  check("a32", 64'(a32), 64'(q32[0].a));
            check("b32", 64'(b32), 64'(q32[0].b));        check("c32", 64'(c32), 64'(q32[0].c));
            check("imm32", 64'(imm32), 64'(q32[0].imm[31:0]));
            check("muxb32", 64'(muxb32), 64'(q32[0].muxb));
            check("cls32", 64'(cls32), 64'(q32[0].cls));
            check("pc32", 64'(pc32), 64'(q32[0].pc[31:0]));
            check("ill32", 64'(ill32), 64'(q32[0].ill));
        end
    endtask

    // Entered and left at a falling edge; models the transfers of the rising edge in between.
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                         input bit ordy, input bit fl);
        check_outputs();
        in_valid = v; in_ins = ins; in_pc = pc; out_ready = ordy; flush = fl;
        if (fl) begin
            q64.delete(); q32.delete();
        end else begin
            bit acc = v && (q64.size() < 2);
            if (q64.size() > 0 && ordy) begin void'(q64.pop_front()); void'(q32.pop_front()); end
            if (acc) begin q64.push_back(model(ins, pc, 1'b1)); q32.push_back(model(ins, pc, 1'b0)); end
        end
        @(negedge clk);
    endtask

    initial begin
        build_table();
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(out_valid64), 64'(0));   check("rst_ready", 64'(in_ready64), 64'(1));
        check("rst_alu", 64'(alu64), 64'(0));           check("rst_cls", 64'(cls64), 64'(0));
        check("rst_ill", 64'(ill64), 64'(0));           check("rst_imm", imm64, 64'(0));
        check("rst_valid32", 64'(out_valid32), 64'(0)); check("rst_pc32", 64'(pc32), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        cycle(1, 32'hFFF10093, 64'h1000, 1, 0);
        check("addi_alu", 64'(alu64), 64'(1));  check("addi_a", 64'(a64), 64'(2));
        check("addi_c", 64'(c64), 64'(1));      check("addi_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_muxb", 64'(muxb64), 64'(1)); check("addi_cls", 64'(cls64), 64'(0));

        cycle(1, 32'h402081B3, 64'h1004, 1, 0);
        check("sub_alu", 64'(alu64), 64'(13));  check("sub_b", 64'(b64), 64'(2));
        cycle(1, 32'h00208463, 64'h1008, 1, 0);
        check("beq_cls", 64'(cls64), 64'(3));   check("beq_imm", imm64, 64'(8));
        check("beq_c", 64'(c64), 64'(0));       check("beq_valid", 64'(out_valid64), 64'(1));
        cycle(0, 32'h0, 64'h0, 1, 0);

        cycle(1, 32'h00100093, 64'h100, 0, 0);
        cycle(1, 32'h00200113, 64'h104, 0, 0);
        check("bp_ready_low", 64'(in_ready64), 64'(0));
        check("bp_hold_pc", pc64, 64'h100);
        cycle(1, 32'h00300193, 64'h108, 1, 0);
        check("bp_second_pc", pc64, 64'h104);
        cycle(1, 32'h00300193, 64'h108, 1, 0);
        check("bp_third_pc", pc64, 64'h108);
        cycle(0, 32'h0, 64'h0, 1, 0);

        cycle(1, 32'h00100093, 64'h200, 0, 0);
        cycle(1, 32'h00200113, 64'h204, 0, 0);
        cycle(1, 32'h00300193, 64'h208, 0, 1);
        check("flush_valid", 64'(out_valid64), 64'(0)); check("flush_ready", 64'(in_ready64), 64'(1));
        cycle(1, 32'h00400213, 64'h20C, 0, 0);
        cycle(1, 32'h00500293, 64'h210, 1, 1);
        check("flush_acc_drop", 64'(out_valid64), 64'(0));
        repeat (3) cycle(0, 32'h0, 64'h0, 1, 0);

        cycle(1, 32'hFFFFFFFF, 64'h300, 1, 0);
        check("ill_flag", 64'(ill64), 64'(1));  check("ill_alu", 64'(alu64), 64'(0));
        check("ill_c", 64'(c64), 64'(0));       check("ill_cls", 64'(cls64), 64'(6));
        cycle(1, 32'h002080BB, 64'h304, 1, 0);
        check("addw64_alu", 64'(alu64), 64'(26)); check("addw64_ill", 64'(ill64), 64'(0));
        check("addw32_ill", 64'(ill32), 64'(1));

        cycle(1, 32'h00100093, 64'h400, 0, 0);
        cycle(1, 32'h00200113, 64'h404, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid64), 64'(0)); check("arst_ready", 64'(in_ready64), 64'(1));
        check("arst_valid32", 64'(out_valid32), 64'(0));
        q64.delete(); q32.delete();
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 600; n++)
            cycle($urandom_range(0, 9) < 7, gen_ins(), {$urandom, $urandom},
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        repeat (3) cycle(0, 32'h0, 64'h0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
